aud_sample_prefetch: RTL and testbench
======================================

AUD_SAMPLE_PREFETCH -- requirements
Module: aud_sample_prefetch

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 16-bit words; power of two, at least 4.
REQ-002 Parameter ADDR_W, default 25, SDRAM word-address width.
REQ-003 clk50  in  1  single system clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  allows new SDRAM reads to be issued.
REQ-006 load  in  1  one-cycle pulse: flush FIFO and restart at start_addr.
REQ-007 start_addr  in  ADDR_W  first word address of the clip.
REQ-008 end_addr  in  ADDR_W  last word address of the clip, inclusive.
REQ-009 ram_rden  out  1  read request to the SDRAM arbiter.
REQ-010 ram_addr  out  ADDR_W  word address of the pending read.
REQ-011 ram_data  in  16  read data, valid in the ram_ack cycle.
REQ-012 ram_ack  in  1  one-cycle acknowledge from the arbiter.
REQ-013 sample_req  in  1  one-cycle pulse from the I2S serializer, one per channel slot.
REQ-014 sample_out  out  16  delivered sample.
REQ-015 sample_valid  out  1  one-cycle strobe qualifying sample_out.
REQ-016 underrun  out  1  sticky flag: a sample_req found the FIFO empty.
REQ-017 fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 The FSM SHALL have three states: IDLE, READ and GAP.
REQ-019 In IDLE, when enable=1, no load is pending and fill_level<DEPTH, the FSM SHALL go to READ on the next edge.
REQ-020 In READ, ram_rden SHALL be 1 and ram_addr SHALL be held stable until ram_ack=1.
REQ-021 ram_ack SHALL be ignored in any state other than READ.
REQ-022 On ram_ack in READ, the block SHALL push ram_data into the FIFO in that cycle and go to GAP.
REQ-023 On that same ram_ack, fetch address SHALL become start_addr if it equals end_addr, otherwise fetch address+1 modulo 2^ADDR_W.
REQ-024 GAP SHALL last exactly one cycle with ram_rden=0, then return to IDLE.
REQ-025 At most one read SHALL be outstanding, so a push never finds the FIFO full.
REQ-026 Deasserting enable during READ SHALL NOT abort the read; the read SHALL complete normally.
REQ-027 A load pulse SHALL set a pending flag; if load and the apply condition coincide, the load SHALL apply in that same cycle.
REQ-028 A pending load SHALL apply in IDLE or GAP, never in READ.
REQ-029 Applying a load SHALL empty the FIFO, set fetch address to start_addr, clear underrun and clear the pending flag.
REQ-030 sample_req with FIFO non-empty SHALL pop the head word; sample_out SHALL hold it and sample_valid=1 on the next cycle (latency 1).
REQ-031 sample_req with FIFO empty SHALL give sample_out=16'h0000 and sample_valid=1 on the next cycle, and SHALL set underrun.
REQ-032 A simultaneous push and pop SHALL both take effect, leaving fill_level unchanged.
REQ-033 A push and pop in the same cycle on an empty FIFO SHALL count as an underrun; the pushed word SHALL remain in the FIFO.
REQ-034 sample_out SHALL hold its last value between strobes.
REQ-035 ram_data SHALL be stored and delivered unmodified, with no sign or byte manipulation.

Reset
REQ-036 On reset_n=0, the block SHALL asynchronously go to: FSM=IDLE, ram_rden=0, ram_addr=0, fetch address=0, FIFO empty, fill_level=0, sample_out=0, sample_valid=0, underrun=0, load pending=0.
REQ-037 Reset during READ SHALL drop ram_rden immediately; the block SHALL NOT push data after reset release without a new READ.
REQ-038 After release, no read SHALL be issued before a load pulse and enable=1.

Structure
REQ-039 Package aud_pkg SHALL hold AUD_FIFO_DEPTH, AUD_ADDR_W and the enum type aud_pf_state_t {IDLE, READ, GAP}.
REQ-040 FIFO storage and pointers SHALL be one sub-module, aud_sync_fifo: push, pop, empty, full, count, flush.
REQ-041 All outputs SHALL be registered except fill_level, which may come straight from the FIFO count.

Verification
REQ-042 Scenario: load with start_addr=0x100, end_addr=0x103, enable=1, arbiter acks 2 cycles after rden -> reads issued in order 0x100, 0x101, 0x102, 0x103, 0x100, ...; FIFO fills to 16 and reads stop.
REQ-043 Scenario: FIFO holds 0xAAAA, 0x5555; three sample_req pulses 10 cycles apart -> outputs 0xAAAA, 0x5555, 0x0000 each one cycle after its request; underrun=1 after the third.
REQ-044 Scenario: load pulse while READ is waiting on ack (ack 5 cycles late) -> rden and address held until ack; then FIFO=0, underrun=0, and the next read address is the new start_addr.
REQ-045 Scenario: FIFO at DEPTH-1 with sample_req in the same cycle as ram_ack -> fill_level stays DEPTH-1; the popped word is the old head.
REQ-046 Scenario: reset_n asserted mid-READ -> ram_rden=0 and all outputs 0 asynchronously; a stray ram_ack after release pushes nothing.
REQ-047 Scenario: enable toggled low during READ -> the read completes, and no further reads are issued while enable=0.

Source files
------------

// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared constants and state type for the audio sample prefetcher
package aud_pkg;

    localparam int AUD_FIFO_DEPTH = 16;
    localparam int AUD_ADDR_W     = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2
    } aud_pf_state_t;

endpackage

// File: rtl/aud_sync_fifo.sv
// rtl/aud_sync_fifo.sv - single-clock word FIFO with flush and occupancy count
module aud_sync_fifo
    import aud_pkg::*;
#(
    parameter int DEPTH = AUD_FIFO_DEPTH,
    parameter int W     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    // A pop on an empty FIFO is dropped even when a push lands in the same cycle.
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/aud_sample_prefetch.sv
// rtl/aud_sample_prefetch.sv - SDRAM clip prefetcher feeding an I2S sample FIFO
module aud_sample_prefetch
    import aud_pkg::*;
#(
    parameter int DEPTH  = AUD_FIFO_DEPTH,
    parameter int ADDR_W = AUD_ADDR_W
) (
    input  logic                     clk50,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     load,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [ADDR_W-1:0]        end_addr,
    output logic                     ram_rden,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [15:0]              ram_data,
    input  logic                     ram_ack,
    input  logic                     sample_req,
    output logic [15:0]              sample_out,
    output logic                     sample_valid,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fill_level
);

    aud_pf_state_t       state_q, state_d;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_rden_q, ram_rden_d;
    logic                load_pend_q, load_pend_d;
    logic                armed_q, armed_d;
    logic [15:0]         sample_out_q, sample_out_d;
    logic                sample_valid_q, sample_valid_d;
    logic                underrun_q, underrun_d;

    logic                apply;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [15:0]         fifo_rdata;

    aud_sync_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
        .clk_i   (clk50),
        .rst_ni  (reset_n),
        .flush_i (apply),
        .push_i  (fifo_push),
        .wdata_i (ram_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fill_level)
    );

    always_comb begin
        state_d        = state_q;
        fetch_addr_d   = fetch_addr_q;
        ram_addr_d     = ram_addr_q;
        load_pend_d    = load_pend_q || load;
        armed_d        = armed_q;
        fifo_push      = 1'b0;
        // A load never interrupts an in-flight read; it waits for IDLE or GAP.
        apply          = (load || load_pend_q) && (state_q != READ);

        case (state_q)
            IDLE: begin
                if (!apply && armed_q && enable && !fifo_full) begin
                    state_d    = READ;
                    ram_addr_d = fetch_addr_q;
                end
            end
            READ: begin
                if (ram_ack) begin
                    fifo_push    = 1'b1;
                    state_d      = GAP;
                    fetch_addr_d = (fetch_addr_q == end_addr) ? start_addr
                                                              : fetch_addr_q + ADDR_W'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (apply) begin
            fetch_addr_d = start_addr;
            load_pend_d  = 1'b0;
            armed_d      = 1'b1;
        end

        ram_rden_d     = (state_d == READ);
        fifo_pop       = sample_req && !fifo_empty;
        sample_valid_d = sample_req;
        sample_out_d   = sample_out_q;
        if (sample_req) sample_out_d = fifo_empty ? 16'h0000 : fifo_rdata;
        underrun_d     = underrun_q || (sample_req && fifo_empty);
        if (apply) underrun_d = 1'b0;
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            fetch_addr_q   <= '0;
            ram_addr_q     <= '0;
            ram_rden_q     <= 1'b0;
            load_pend_q    <= 1'b0;
            armed_q        <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_addr_q   <= fetch_addr_d;
            ram_addr_q     <= ram_addr_d;
            ram_rden_q     <= ram_rden_d;
            load_pend_q    <= load_pend_d;
            armed_q        <= armed_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
        end
    end

    assign ram_rden     = ram_rden_q;
    assign ram_addr     = ram_addr_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_aud_sample_prefetch.sv
// tb/tb_aud_sample_prefetch.sv - directed self-checking bench for aud_sample_prefetch
module tb_aud_sample_prefetch;

    logic        clk50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [24:0] start_addr = '0;
    logic [24:0] end_addr = '0;
    logic        ram_rden;
    logic [24:0] ram_addr;
    logic [15:0] ram_data = '0;
    logic        ram_ack = 1'b0;
    logic        sample_req = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        underrun;
    logic [4:0]  fill_level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] ram_img [16];
    logic [24:0] acked [$];
    int          ack_delay = 2;
    bit          arb_on = 1'b1;
    int          wait_cnt = 0;
    int          rden_rises = 0;
    int          addr_moves = 0;
    logic        rden_prev = 1'b0;
    logic [24:0] addr_prev = '0;
    int          r0;
    logic [15:0] exp3 [3];

    aud_sample_prefetch dut (
        .clk50        (clk50),
        .reset_n      (reset_n),
        .enable       (enable),
        .load         (load),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .ram_rden     (ram_rden),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_ack      (ram_ack),
        .sample_req   (sample_req),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .underrun     (underrun),
        .fill_level   (fill_level)
    );

    initial forever #10 clk50 = ~clk50;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Arbiter model: acks ack_delay cycles after rden rises, data from ram_img.
    always @(posedge clk50) begin
        #1;
        if (ram_rden && rden_prev && ram_addr != addr_prev) addr_moves++;
        if (ram_rden && !rden_prev) rden_rises++;
        rden_prev = ram_rden;
        addr_prev = ram_addr;
        if (arb_on) begin
            ram_ack = 1'b0;
            if (ram_rden) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    ram_ack  = 1'b1;
                    ram_data = ram_img[ram_addr[3:0]];
                    acked.push_back(ram_addr);
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk50);
        load = 1'b0;
    endtask

    task automatic pulse_req();
        sample_req = 1'b1;
        @(negedge clk50);
        sample_req = 1'b0;
    endtask

    task automatic wait_rden(input logic level, input int budget, input string tag);
        for (int i = 0; i < budget && ram_rden !== level; i++) @(negedge clk50);
        chk(tag, 32'(ram_rden), 32'(level));
    endtask

    task automatic wait_fill(input int v, input int budget, input string tag);
        for (int i = 0; i < budget && int'(fill_level) != v; i++) @(negedge clk50);
        chk(tag, 32'(fill_level), 32'(v));
    endtask

    task automatic wait_ack(input int budget, input string tag);
        for (int i = 0; i < budget && ram_ack !== 1'b1; i++) @(negedge clk50);
        chk(tag, 32'(ram_ack), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram_img[i] = 16'hD000 | 16'(i);
        ram_img[0] = 16'h1234;
        ram_img[1] = 16'h8001;
        ram_img[2] = 16'hFFFF;
        ram_img[3] = 16'h00F0;
        ram_img[8] = 16'hAAAA;
        ram_img[9] = 16'h5555;
        exp3[0] = 16'hAAAA;
        exp3[1] = 16'h5555;
        exp3[2] = 16'h0000;

        repeat (3) @(negedge clk50);
        chk("rst_rden", 32'(ram_rden), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_out", 32'(sample_out), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        // No reads before the first load, even with enable high.
        reset_n    = 1'b1;
        enable     = 1'b1;
        start_addr = 25'h100;
        end_addr   = 25'h103;
        cyc(20);
        chk("no_read_before_load", 32'(rden_rises), 32'd0);

        // Clip 0x100..0x103 wraps, FIFO fills to DEPTH and reads stop.
        acked.delete();
        pulse_load();
        wait_fill(16, 300, "fill_to_depth");
        cyc(30);
        chk("reads_stop_cnt", 32'(acked.size()), 32'd16);
        chk("reads_stop_rden", 32'(ram_rden), 32'd0);
        chk("reads_stop_fill", 32'(fill_level), 32'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("rd_addr%0d", i), 32'(acked[i]), 32'h100 + 32'(i % 4));
        chk("addr_stable_in_read", 32'(addr_moves), 32'd0);

        // Pop from full, then pop on the same edge as the refill ack.
        ack_delay = 6;
        pulse_req();
        chk("pop0_valid", 32'(sample_valid), 32'd1);
        chk("pop0_data", 32'(sample_out), 32'h1234);
        wait_ack(60, "pushpop_ack");
        pulse_req();
        chk("pushpop_fill", 32'(fill_level), 32'd15);
        chk("pushpop_data", 32'(sample_out), 32'h8001);

        // Two words, three requests; third underruns.
        enable = 1'b0;
        cyc(30);
        start_addr = 25'h8;
        end_addr   = 25'h9;
        ack_delay  = 2;
        enable     = 1'b1;
        pulse_load();
        wait_fill(2, 40, "fill_two");
        enable = 1'b0;
        cyc(10);
        chk("fill_hold2", 32'(fill_level), 32'd2);
        for (int k = 0; k < 3; k++) begin
            pulse_req();
            chk($sformatf("req%0d_valid", k), 32'(sample_valid), 32'd1);
            chk($sformatf("req%0d_data", k), 32'(sample_out), 32'(exp3[k]));
            chk($sformatf("req%0d_underrun", k), 32'(underrun), 32'(k == 2));
            @(negedge clk50);
            chk($sformatf("req%0d_strobe_end", k), 32'(sample_valid), 32'd0);
            chk($sformatf("req%0d_out_held", k), 32'(sample_out), 32'(exp3[k]));
            cyc(8);
        end

        // Load during a READ waiting on a late ack.
        ack_delay = 8;
        enable    = 1'b1;
        wait_rden(1'b1, 20, "late_rd_start");
        chk("late_rd_addr", 32'(ram_addr), 32'h8);
        cyc(2);
        start_addr = 25'h200;
        end_addr   = 25'h203;
        pulse_load();
        cyc(2);
        chk("late_rden_held", 32'(ram_rden), 32'd1);
        chk("late_addr_held", 32'(ram_addr), 32'h8);
        wait_rden(1'b0, 20, "late_ack_done");
        @(negedge clk50);
        chk("load_flush_fill", 32'(fill_level), 32'd0);
        chk("load_clr_underrun", 32'(underrun), 32'd0);
        ack_delay = 2;
        wait_rden(1'b1, 20, "new_rd_start");
        chk("new_start_addr", 32'(ram_addr), 32'h200);

        // Dropping enable mid-READ lets the read finish, then stops.
        enable = 1'b0;
        wait_rden(1'b0, 20, "en_low_done");
        chk("en_low_fill", 32'(fill_level), 32'd1);
        r0 = rden_rises;
        cyc(20);
        chk("en_low_no_reads", 32'(rden_rises), 32'(r0));

        // Asynchronous reset in the middle of a READ.
        pulse_req();
        chk("pre_rst_pop", 32'(sample_out), 32'h1234);
        pulse_req();
        chk("pre_rst_underrun", 32'(underrun), 32'd1);
        enable = 1'b1;
        wait_fill(1, 20, "pre_rst_refill");
        ack_delay = 20;
        pulse_req();
        chk("pre_rst_out", 32'(sample_out), 32'h8001);
        wait_rden(1'b1, 20, "pre_rst_read");
        arb_on = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_rden", 32'(ram_rden), 32'd0);
        chk("arst_addr", 32'(ram_addr), 32'd0);
        chk("arst_fill", 32'(fill_level), 32'd0);
        chk("arst_out", 32'(sample_out), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        @(negedge clk50);
        reset_n  = 1'b1;
        ram_ack  = 1'b1;
        ram_data = 16'hBEEF;
        @(negedge clk50);
        ram_ack = 1'b0;
        chk("stray_ack_fill", 32'(fill_level), 32'd0);
        r0 = rden_rises;
        cyc(10);
        chk("post_rst_no_read", 32'(rden_rises), 32'(r0));

        arb_on    = 1'b1;
        ack_delay = 2;
        pulse_load();
        wait_rden(1'b1, 20, "post_rst_read");
        chk("post_rst_addr", 32'(ram_addr), 32'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
